// File: rtl/regfile_wport_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter
//   Shares the register file's single write port between the core writeback
//   (priority) and a buffered long-latency secondary requester. Keeps a
//   per-register scoreboard of outstanding secondary results for read hazard
//   detection. A starvation counter forces a core stall so that buffered
//   writes always drain.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   core_we/core_wreg/core_wdata    core writeback request
//   sec_valid/sec_wreg/sec_wdata    secondary write request (valid/ready)
//   sec_ready                       buffer can accept a secondary write
//   rsv_valid/rsv_reg               reserve a register at secondary issue
//   rs_addr/rt_addr                 core read addresses for hazard check
//   hazard                          a read address is reserved
//   stall_req                       forced core stall (core write ignored)
//   waw_err                         sticky: core wrote a reserved register
//   rf_regwrite/rf_writereg/rf_writedata   register file write port
// -----------------------------------------------------------------------------

package regfile_wport_arbiter_pkg;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  // One buffered secondary write
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } wr_req_t;
endpackage

module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we,
  input  logic [REG_W-1:0]  core_wreg,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              sec_valid,
  input  logic [REG_W-1:0]  sec_wreg,
  input  logic [DATA_W-1:0] sec_wdata,
  output logic              sec_ready,
  input  logic              rsv_valid,
  input  logic [REG_W-1:0]  rsv_reg,
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  output logic              hazard,
  output logic              stall_req,
  output logic              waw_err,
  output logic              rf_regwrite,
  output logic [REG_W-1:0]  rf_writereg,
  output logic [DATA_W-1:0] rf_writedata
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = AW + 1;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned NREG   = 1 << REG_W;

  // State
  wr_req_t           mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic              waw_err_q, waw_err_d;

  // Combinational control
  logic    empty;
  logic    full;
  logic    core_ok;
  logic    fifo_grant;
  logic    push;
  wr_req_t head;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign sec_ready  = !full;
  assign stall_req  = !empty && (wait_cnt_q == WAIT_W'(MAX_WAIT));
  assign core_ok    = core_we && (core_wreg != '0) && !stall_req;
  assign fifo_grant = !core_ok && !empty;
  // Writes to $0 complete the handshake but are dropped here
  assign push       = sec_valid && !full && (sec_wreg != '0);

  assign hazard = ((rs_addr != '0) && sb_q[rs_addr]) ||
                  ((rt_addr != '0) && sb_q[rt_addr]);

  assign waw_err = waw_err_q;

  // Write port mux: core first, then buffered head, else idle
  always_comb begin
    rf_regwrite  = 1'b0;
    rf_writereg  = '0;
    rf_writedata = '0;
    if (core_ok) begin
      rf_regwrite  = 1'b1;
      rf_writereg  = core_wreg;
      rf_writedata = core_wdata;
    end else if (fifo_grant) begin
      rf_regwrite  = 1'b1;
      rf_writereg  = head.wreg;
      rf_writedata = head.wdata;
    end
  end

  // Next-state for pointers, occupancy, starvation counter, scoreboard
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wait_cnt_d = wait_cnt_q;
    sb_d       = sb_q;
    waw_err_d  = waw_err_q;

    if (push)       wr_ptr_d = wr_ptr_q + AW'(1);
    if (fifo_grant) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(fifo_grant);

    // Non-empty and not FIFO-granted means the core took the port
    if (empty || fifo_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    // Clear before set so a same-cycle reservation wins
    if (fifo_grant)                    sb_d[head.wreg] = 1'b0;
    if (rsv_valid && (rsv_reg != '0))  sb_d[rsv_reg]   = 1'b1;
    sb_d[0] = 1'b0;

    if (core_ok && sb_q[core_wreg]) waw_err_d = 1'b1;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      sb_q       <= '0;
      waw_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      sb_q       <= sb_d;
      waw_err_q  <= waw_err_d;
    end
  end

  // Buffer storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].wreg  <= sec_wreg;
      mem_q[wr_ptr_q].wdata <= sec_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_wreg;
  logic [31:0] core_wdata;
  logic        sec_valid;
  logic [4:0]  sec_wreg;
  logic [31:0] sec_wdata;
  logic        sec_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard;
  logic        stall_req;
  logic        waw_err;
  logic        rf_regwrite;
  logic [4:0]  rf_writereg;
  logic [31:0] rf_writedata;

  int errors = 0;
  int checks = 0;

  regfile_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_wreg(core_wreg), .core_wdata(core_wdata),
    .sec_valid(sec_valid), .sec_wreg(sec_wreg), .sec_wdata(sec_wdata),
    .sec_ready(sec_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .hazard(hazard), .stall_req(stall_req), .waw_err(waw_err),
    .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_we = 0; core_wreg = 0; core_wdata = 0;
    sec_valid = 0; sec_wreg = 0; sec_wdata = 0;
    rsv_valid = 0; rsv_reg = 0; rs_addr = 0; rt_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    #1;
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL reset_sec_ready: got %b want 1", sec_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw: got %b want 0", waw_err); end
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", rf_regwrite); end
    checks++; if (rf_writereg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %0d want 0", rf_writereg); end
    checks++; if (rf_writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata: got %h want 0", rf_writedata); end
  endtask

  task automatic test_core_only();
    tick();
    core_we = 1; core_wreg = 5'd5; core_wdata = 32'hA5A5_A5A5;
    #1;
    checks++; if (rf_regwrite !== 1'b1) begin errors++; $display("FAIL core_regwrite: got %b want 1", rf_regwrite); end
    checks++; if (rf_writereg !== 5'd5) begin errors++; $display("FAIL core_writereg: got %0d want 5", rf_writereg); end
    checks++; if (rf_writedata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL core_writedata: got %h want a5a5a5a5", rf_writedata); end
    tick();
    core_wreg = 5'd0; core_wdata = 32'hFFFF_0000;
    #1;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL core_r0_regwrite: got %b want 0", rf_regwrite); end
    idle_inputs();
  endtask

  task automatic test_secondary();
    tick();
    sec_valid = 1; sec_wreg = 5'd9; sec_wdata = 32'h0000_1234;
    #1;
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL sec_ready_empty: got %b want 1", sec_ready); end
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL sec_no_bypass: got %b want 0", rf_regwrite); end
    tick();
    sec_valid = 0;
    #1;
    checks++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd9) begin errors++; $display("FAIL sec_grant: got we=%b reg=%0d want we=1 reg=9", rf_regwrite, rf_writereg); end
    checks++; if (rf_writedata !== 32'h0000_1234) begin errors++; $display("FAIL sec_data: got %h want 00001234", rf_writedata); end
    tick();
    // $0 secondary write: accepted but never written
    sec_valid = 1; sec_wreg = 5'd0; sec_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL sec_empty_after: got %b want 0", rf_regwrite); end
    tick();
    sec_valid = 0;
    #1;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL sec_r0_dropped: got %b want 0", rf_regwrite); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    tick();
    core_we = 1; core_wreg = 5'd4; core_wdata = 32'h0000_0044;
    sec_valid = 1; sec_wreg = 5'd10; sec_wdata = 32'h0000_00AA;
    #1;
    tick();
    sec_valid = 0;
    // Four cycles denied to the buffered write
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (stall_req !== 1'b0 || rf_writereg !== 5'd4) begin errors++; $display("FAIL starve_denied_%0d: got stall=%b reg=%0d want stall=0 reg=4", i, stall_req, rf_writereg); end
      tick();
    end
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", stall_req); end
    checks++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd10 || rf_writedata !== 32'hAA) begin errors++; $display("FAIL starve_grant: got we=%b reg=%0d data=%h want we=1 reg=10 data=aa", rf_regwrite, rf_writereg, rf_writedata); end
    tick();
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", stall_req); end
    checks++; if (rf_writereg !== 5'd4) begin errors++; $display("FAIL starve_core_back: got %0d want 4", rf_writereg); end
    idle_inputs();
  endtask

  task automatic test_full();
    tick();
    core_we = 1; core_wreg = 5'd2; core_wdata = 32'h22;
    sec_valid = 1; sec_wreg = 5'd11; sec_wdata = 32'hB1;
    #1;
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL full_push1_ready: got %b want 1", sec_ready); end
    tick();
    sec_wreg = 5'd12; sec_wdata = 32'hB2;
    #1;
    checks++; if (sec_ready !== 1'b1) begin errors++; $display("FAIL full_push2_ready: got %b want 1", sec_ready); end
    tick();
    sec_wreg = 5'd13; sec_wdata = 32'hB3;
    #1;
    checks++; if (sec_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", sec_ready); end
    checks++; if (rf_writereg !== 5'd2) begin errors++; $display("FAIL full_core_wins: got %0d want 2", rf_writereg); end
    tick();
    core_we = 0;
    #1;
    checks++; if (sec_ready !== 1'b0 || rf_writereg !== 5'd11) begin errors++; $display("FAIL full_drain: got ready=%b reg=%0d want ready=0 reg=11", sec_ready, rf_writereg); end
    tick();
    #1;
    checks++; if (sec_ready !== 1'b1 || rf_writereg !== 5'd12) begin errors++; $display("FAIL full_after_drain: got ready=%b reg=%0d want ready=1 reg=12", sec_ready, rf_writereg); end
    tick();
    sec_valid = 0;
    #1;
    checks++; if (rf_writereg !== 5'd13 || rf_writedata !== 32'hB3) begin errors++; $display("FAIL full_held_write: got reg=%0d data=%h want reg=13 data=b3", rf_writereg, rf_writedata); end
    tick();
    #1;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL full_empty_end: got %b want 0", rf_regwrite); end
    idle_inputs();
  endtask

  task automatic test_hazard();
    tick();
    rsv_valid = 1; rsv_reg = 5'd7; rs_addr = 5'd7;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_before_set: got %b want 0", hazard); end
    tick();
    rsv_valid = 0;
    core_we = 1; core_wreg = 5'd7; core_wdata = 32'h70;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_set: got %b want 1", hazard); end
    tick();
    core_we = 0;
    sec_valid = 1; sec_wreg = 5'd7; sec_wdata = 32'h77;
    #1;
    checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL hz_waw: got %b want 1", waw_err); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_kept: got %b want 1", hazard); end
    tick();
    sec_valid = 0;
    #1;
    checks++; if (rf_writereg !== 5'd7 || hazard !== 1'b1) begin errors++; $display("FAIL hz_grant: got reg=%0d hz=%b want reg=7 hz=1", rf_writereg, hazard); end
    tick();
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_cleared: got %b want 0", hazard); end
    // Reserve r14 via rt, then re-reserve it in the cycle its write drains
    rs_addr = 5'd0; rt_addr = 5'd14;
    rsv_valid = 1; rsv_reg = 5'd14;
    sec_valid = 1; sec_wreg = 5'd14; sec_wdata = 32'hE;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_rs0: got %b want 0", hazard); end
    tick();
    sec_valid = 0;
    #1;
    checks++; if (hazard !== 1'b1 || rf_writereg !== 5'd14) begin errors++; $display("FAIL hz_rt_set: got hz=%b reg=%0d want hz=1 reg=14", hazard, rf_writereg); end
    tick();
    rsv_valid = 0;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_set_wins: got %b want 1", hazard); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
    core_we = 1; core_wreg = 5'd1; core_wdata = 32'h1;
    sec_valid = 1; sec_wreg = 5'd20; sec_wdata = 32'h20;
    rsv_valid = 1; rsv_reg = 5'd3;
    tick();
    sec_wreg = 5'd21; sec_wdata = 32'h21;
    rsv_valid = 0; rs_addr = 5'd3;
    tick();
    sec_valid = 0;
    #1;
    checks++; if (sec_ready !== 1'b0 || hazard !== 1'b1) begin errors++; $display("FAIL rst_pre: got ready=%b hz=%b want ready=0 hz=1", sec_ready, hazard); end
    core_we = 0;
    rst_n = 0;
    #1;
    checks++; if (rf_regwrite !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL rst_async: got we=%b hz=%b want we=0 hz=0", rf_regwrite, hazard); end
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_regwrite !== 1'b0 || hazard !== 1'b0 || sec_ready !== 1'b1) begin errors++; $display("FAIL rst_after_%0d: got we=%b hz=%b ready=%b want 0 0 1", i, rf_regwrite, hazard, sec_ready); end
    end
    checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL rst_waw: got %b want 0", waw_err); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_secondary();
    test_starvation();
    test_full();
    test_hazard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
